// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 raster timing, pixel tick, counters and
// registered VGA pins.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   rgb_in[2:0]     colour for the current HCount/VCount
//   HCount, VCount  10-bit raster position
//   pixel_tick      one-clk pulse every CLK_DIV clks
//   video_on        visible-area flag, aligned with the counts
//   frame_start     one-clk pulse after the counts wrap to (0,0)
//   vga_hsync/vsync active-low syncs, one pixel behind the counts
//   vga_rgb[2:0]    blanked colour, one pixel behind the counts
module vga_sync_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       pixel_tick,
  output logic       video_on,
  output logic       frame_start,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [2:0] vga_rgb
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          wrap;
  logic          hsync_pre;
  logic          vsync_pre;

  always_comb begin
    h_nxt = HCount;
    v_nxt = VCount;
    wrap  = 1'b0;
    if (pixel_tick) begin
      if (HCount == H_LAST) begin
        h_nxt = '0;
        if (VCount == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = VCount + 10'd1;
        end
      end else begin
        h_nxt = HCount + 10'd1;
      end
    end
  end

  // Decodes look at the next-state counts so that, being registered,
  // they line up with HCount/VCount in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      pixel_tick  <= 1'b0;
      HCount      <= '0;
      VCount      <= '0;
      video_on    <= 1'b1;
      hsync_pre   <= 1'b1;
      vsync_pre   <= 1'b1;
      frame_start <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_rgb     <= '0;
    end else begin
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pixel_tick  <= (div_cnt == DIV_LAST);
      HCount      <= h_nxt;
      VCount      <= v_nxt;
      video_on    <= (h_nxt < H_VEND) && (v_nxt < V_VEND);
      hsync_pre   <= !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
      vsync_pre   <= !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
      frame_start <= wrap;
      // Pins sample the decodes of the pixel being left, so they
      // trail the counts by exactly one pixel and stay aligned.
      if (pixel_tick) begin
        vga_rgb   <= video_on ? rgb_in : 3'b000;
        vga_hsync <= hsync_pre;
        vga_vsync <= vsync_pre;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// Full-size timing at CLK_DIV=2 plus a shrunken raster at CLK_DIV=1.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [2:0] rgb_a, rgb_b;
  logic [9:0] h_a, v_a, h_b, v_b;
  logic       tick_a, von_a, fs_a, hs_a, vs_a;
  logic       tick_b, von_b, fs_b, hs_b, vs_b;
  logic [2:0] vrgb_a, vrgb_b;

  vga_sync_gen dut_a (
    .clk(clk), .reset(rst_a), .rgb_in(rgb_a),
    .HCount(h_a), .VCount(v_a), .pixel_tick(tick_a),
    .video_on(von_a), .frame_start(fs_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_rgb(vrgb_a)
  );

  // 15x8 raster: H 0..7 vis, 8..9 fp, 10..12 sync, 13..14 bp;
  // V 0..3 vis, 4 fp, 5..6 sync, 7 bp.
  vga_sync_gen #(
    .CLK_DIV(1),
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .rgb_in(rgb_b),
    .HCount(h_b), .VCount(v_b), .pixel_tick(tick_b),
    .video_on(von_b), .frame_start(fs_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_rgb(vrgb_b)
  );

  typedef struct {
    logic       rst;
    logic [2:0] rgb;
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic [2:0] vrgb;
    logic       von;
    logic       fs;
  } vec_t;

  vec_t tbl [12];

  int checks = 0;
  int errors = 0;

  int hs_low0, first_hs_h, wrap_v, wrap1, wrap2;
  int von639, von640, rgb_vis, rgb_blank, fs_cnt, prev_h;
  int tick_cnt, fs1, fs2, fs_pos, vs_low, vs_h, vs_v;
  int hs_low_b, rgb_on, rgb_bad, found;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic rst, input logic [2:0] rgb, input logic tick,
    input logic [9:0] h, input logic [2:0] vrgb
  );
    vec_t t;
    t.rst  = rst;
    t.rgb  = rgb;
    t.tick = tick;
    t.h    = h;
    t.v    = 10'd0;
    t.hs   = 1'b1;
    t.vs   = 1'b1;
    t.vrgb = vrgb;
    t.von  = 1'b1;
    t.fs   = 1'b0;
    return t;
  endfunction

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rgb_a = 3'd0;
    rgb_b = 3'd0;

    // Per-clk vectors: tick every 2nd clk, counts and pins trailing.
    tbl[0]  = mk(1'b1, 3'd5, 1'b0, 10'd0, 3'd0);
    tbl[1]  = mk(1'b1, 3'd5, 1'b0, 10'd0, 3'd0);
    tbl[2]  = mk(1'b0, 3'd5, 1'b0, 10'd0, 3'd0);
    tbl[3]  = mk(1'b0, 3'd5, 1'b1, 10'd0, 3'd0);
    tbl[4]  = mk(1'b0, 3'd5, 1'b0, 10'd1, 3'd5);
    tbl[5]  = mk(1'b0, 3'd5, 1'b1, 10'd1, 3'd5);
    tbl[6]  = mk(1'b0, 3'd3, 1'b0, 10'd2, 3'd3);
    tbl[7]  = mk(1'b0, 3'd3, 1'b1, 10'd2, 3'd3);
    tbl[8]  = mk(1'b1, 3'd3, 1'b0, 10'd0, 3'd0);
    tbl[9]  = mk(1'b0, 3'd3, 1'b0, 10'd0, 3'd0);
    tbl[10] = mk(1'b0, 3'd3, 1'b1, 10'd0, 3'd0);
    tbl[11] = mk(1'b0, 3'd0, 1'b0, 10'd1, 3'd0);

    for (int i = 0; i < 12; i++) begin
      rst_a = tbl[i].rst;
      rgb_a = tbl[i].rgb;
      step();
      chk($sformatf("v%0d tick", i), int'(tick_a), int'(tbl[i].tick));
      chk($sformatf("v%0d hcnt", i), int'(h_a), int'(tbl[i].h));
      chk($sformatf("v%0d vcnt", i), int'(v_a), int'(tbl[i].v));
      chk($sformatf("v%0d hs", i), int'(hs_a), int'(tbl[i].hs));
      chk($sformatf("v%0d vs", i), int'(vs_a), int'(tbl[i].vs));
      chk($sformatf("v%0d rgb", i), int'(vrgb_a), int'(tbl[i].vrgb));
      chk($sformatf("v%0d von", i), int'(von_a), int'(tbl[i].von));
      chk($sformatf("v%0d fs", i), int'(fs_a), int'(tbl[i].fs));
    end

    // Full-size lines at CLK_DIV=2.
    rgb_a = 3'd1;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    hs_low0 = 0; first_hs_h = -1; wrap_v = -1; wrap1 = -1; wrap2 = -1;
    von639 = -1; von640 = -1; rgb_vis = -1; rgb_blank = -1; fs_cnt = 0;
    prev_h = int'(h_a);
    for (int n = 1; n <= 12 * 1600 + 40; n++) begin
      step();
      if (!hs_a && v_a == 10'd0) hs_low0++;
      if (!hs_a && first_hs_h < 0) first_hs_h = int'(h_a);
      if (prev_h == 799 && h_a == 10'd0) begin
        if (wrap1 < 0) begin
          wrap1  = n;
          wrap_v = int'(v_a);
        end else if (wrap2 < 0) begin
          wrap2 = n;
        end
      end
      if (h_a == 10'd639 && v_a == 10'd0 && von639 < 0) von639 = int'(von_a);
      if (h_a == 10'd640 && v_a == 10'd0 && von640 < 0) von640 = int'(von_a);
      if (h_a == 10'd11 && v_a == 10'd10 && rgb_vis < 0) rgb_vis = int'(vrgb_a);
      if (h_a == 10'd701 && v_a == 10'd10 && rgb_blank < 0) rgb_blank = int'(vrgb_a);
      if (fs_a) fs_cnt++;
      prev_h = int'(h_a);
    end
    chk("hsync low clks", hs_low0, 192);
    chk("hsync first low h", first_hs_h, 657);
    chk("wrap vcount", wrap_v, 1);
    chk("line period", wrap2 - wrap1, 1600);
    chk("von h639", von639, 1);
    chk("von h640", von640, 0);
    chk("rgb at 11,10", rgb_vis, 1);
    chk("rgb at 701,10", rgb_blank, 0);
    chk("no fs in lines", fs_cnt, 0);

    // Shrunken raster at CLK_DIV=1: 120 clks per frame.
    rgb_b = 3'd7;
    rst_b = 1'b1;
    step();
    step();
    rst_b = 1'b0;
    tick_cnt = 0; fs1 = -1; fs2 = -1; fs_pos = -1;
    vs_low = 0; vs_h = -1; vs_v = -1; hs_low_b = 0;
    rgb_on = 0; rgb_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (tick_b) tick_cnt++;
      if (fs_b) begin
        if (fs1 < 0) begin
          fs1 = k;
          fs_pos = int'(h_b) + int'(v_b);
        end else if (fs2 < 0) begin
          fs2 = k;
        end
      end
      if (k <= 120 && !vs_b) begin
        vs_low++;
        if (vs_h < 0) begin
          vs_h = int'(h_b);
          vs_v = int'(v_b);
        end
      end
      if (k <= 15 && !hs_b) hs_low_b++;
      if (k <= 120 && vrgb_b == 3'd7) rgb_on++;
      if (v_b >= 10'd4 && vrgb_b != 3'd0) rgb_bad++;
    end
    chk("div1 tick count", tick_cnt, 300);
    chk("first fs clk", fs1, 121);
    chk("fs period", fs2 - fs1, 120);
    chk("fs at origin", fs_pos, 0);
    chk("vsync low clks", vs_low, 30);
    chk("vsync first low v", vs_v, 5);
    chk("vsync first low h", vs_h, 1);
    chk("div1 hsync low", hs_low_b, 3);
    chk("visible rgb count", rgb_on, 32);
    chk("blank rgb lines", rgb_bad, 0);

    // Reset on the last pixel of a frame: it must win over the wrap.
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (h_b == 10'd14 && v_b == 10'd7) found = 1;
      else step();
    end
    chk("reached 14,7", found, 1);
    rst_b = 1'b1;
    step();
    chk("mid rst hcnt", int'(h_b), 0);
    chk("mid rst vcnt", int'(v_b), 0);
    chk("mid rst fs", int'(fs_b), 0);
    chk("mid rst tick", int'(tick_b), 0);
    chk("mid rst hs", int'(hs_b), 1);
    chk("mid rst vs", int'(vs_b), 1);
    chk("mid rst rgb", int'(vrgb_b), 0);
    chk("mid rst von", int'(von_b), 1);
    rst_b = 1'b0;
    fs_cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (fs_b) fs_cnt++;
    end
    chk("no fs after rst", fs_cnt, 0);
    chk("restart hcnt", int'(h_b), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
